// File: rtl/riscv_lsu_pkg.sv
// Shared types for the memory-stage load/store unit: FSM states, load/store size
// encodings and the byte-strobe table indexed by store size.
package riscv_lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_DRAIN = 3'd4
   } lsu_state_t;

   localparam logic [2:0] MEXT_LB  = 3'b000;
   localparam logic [2:0] MEXT_LH  = 3'b001;
   localparam logic [2:0] MEXT_LW  = 3'b010;
   localparam logic [2:0] MEXT_LD  = 3'b011;
   localparam logic [2:0] MEXT_LBU = 3'b100;
   localparam logic [2:0] MEXT_LHU = 3'b101;
   localparam logic [2:0] MEXT_LWU = 3'b110;

   localparam logic [1:0] SSRC_SB = 2'b00;
   localparam logic [1:0] SSRC_SH = 2'b01;
   localparam logic [1:0] SSRC_SW = 2'b10;
   localparam logic [1:0] SSRC_SD = 2'b11;

   // Unshifted byte enables for each store size; shifted into place by the address offset.
   function automatic logic [7:0] strb_base(input logic [1:0] size);
      case (size)
         SSRC_SB: return 8'h01;
         SSRC_SH: return 8'h03;
         SSRC_SW: return 8'h0F;
         SSRC_SD: return 8'hFF;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/riscv_lsu_extend.sv
// Load-data lane select and extension: moves the addressed bytes of the 64-bit
// read word down to bit 0, then sign- or zero-extends according to the load type.
module riscv_lsu_extend
   import riscv_lsu_pkg::*;
#(
   parameter int width = 64
) (
   input  logic [width-1:0] rdata,
   input  logic [2:0]       off,
   input  logic [2:0]       memext,
   output logic [width-1:0] loaddata
);

   logic [width-1:0] shifted;

   always_comb begin
      shifted  = rdata >> {off, 3'b000};
      loaddata = shifted;
      case (memext)
         MEXT_LB:  loaddata = {{(width-8){shifted[7]}},   shifted[7:0]};
         MEXT_LH:  loaddata = {{(width-16){shifted[15]}}, shifted[15:0]};
         MEXT_LW:  loaddata = {{(width-32){shifted[31]}}, shifted[31:0]};
         MEXT_LBU: loaddata = {{(width-8){1'b0}},         shifted[7:0]};
         MEXT_LHU: loaddata = {{(width-16){1'b0}},        shifted[15:0]};
         MEXT_LWU: loaddata = {{(width-32){1'b0}},        shifted[31:0]};
         MEXT_LD:  loaddata = shifted;
         // 3'b111 is not a defined load type; it behaves as a plain doubleword load
         default:  loaddata = shifted;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Memory-stage load/store unit: captures one M-stage access, runs it over the
// req/gnt/rvalid data port, stalls while it is in flight and returns extended load data.
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int width  = 64,
   parameter int STRB_W = width / 8
) (
   input  logic              i_riscv_lsu_clk,
   input  logic              i_riscv_lsu_rst,
   input  logic              i_riscv_lsu_valid,
   input  logic              i_riscv_lsu_memread,
   input  logic              i_riscv_lsu_memwrite,
   input  logic [2:0]        i_riscv_lsu_memext,
   input  logic [1:0]        i_riscv_lsu_storesrc,
   input  logic [width-1:0]  i_riscv_lsu_addr,
   input  logic [width-1:0]  i_riscv_lsu_storedata,
   input  logic              i_riscv_lsu_misaligned,
   input  logic              i_riscv_lsu_flush,
   output logic              o_riscv_lsu_dmem_req,
   output logic              o_riscv_lsu_dmem_we,
   output logic [width-1:0]  o_riscv_lsu_dmem_addr,
   output logic [width-1:0]  o_riscv_lsu_dmem_wdata,
   output logic [STRB_W-1:0] o_riscv_lsu_dmem_strb,
   input  logic              i_riscv_lsu_dmem_gnt,
   input  logic              i_riscv_lsu_dmem_rvalid,
   input  logic [width-1:0]  i_riscv_lsu_dmem_rdata,
   output logic [width-1:0]  o_riscv_lsu_loaddata,
   output logic              o_riscv_lsu_done,
   output logic              o_riscv_lsu_stall,
   output logic [2:0]        o_riscv_lsu_state
);

   // Handshake: a request is presented while req=1 and is held unchanged until the
   // cycle gnt=1, which transfers it. Exactly one rvalid per granted request follows,
   // possibly in the grant cycle itself; rvalid outside an outstanding request is ignored.

   lsu_state_t         state_q;
   lsu_state_t         state_d;
   logic               accept;
   logic               capture_rdata;

   logic [width-1:0]   addr_q;
   logic [2:0]         off_q;
   logic               we_q;
   logic [2:0]         memext_q;
   logic [STRB_W-1:0]  strb_q;
   logic [width-1:0]   wdata_q;
   logic [width-1:0]   rdata_q;
   logic [width-1:0]   ext_data;

   assign accept = (state_q == ST_IDLE) & i_riscv_lsu_valid
                 & (i_riscv_lsu_memread | i_riscv_lsu_memwrite)
                 & ~i_riscv_lsu_misaligned & ~i_riscv_lsu_flush;

   always_comb begin
      state_d       = state_q;
      capture_rdata = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (i_riscv_lsu_dmem_gnt) begin
               capture_rdata = i_riscv_lsu_dmem_rvalid;
               if (i_riscv_lsu_flush)
                  state_d = i_riscv_lsu_dmem_rvalid ? ST_IDLE : ST_DRAIN;
               else
                  state_d = i_riscv_lsu_dmem_rvalid ? ST_RESP : ST_WAIT;
            end else if (i_riscv_lsu_flush) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            capture_rdata = i_riscv_lsu_dmem_rvalid;
            if (i_riscv_lsu_dmem_rvalid)
               state_d = i_riscv_lsu_flush ? ST_IDLE : ST_RESP;
            else if (i_riscv_lsu_flush)
               state_d = ST_DRAIN;
         end
         // The bus still owes a response for a flushed access; swallow it here.
         ST_DRAIN: begin
            if (i_riscv_lsu_dmem_rvalid) state_d = ST_IDLE;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_riscv_lsu_clk or negedge i_riscv_lsu_rst) begin
      if (!i_riscv_lsu_rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         off_q    <= '0;
         we_q     <= 1'b0;
         memext_q <= '0;
         strb_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q   <= {i_riscv_lsu_addr[width-1:3], 3'b000};
            off_q    <= i_riscv_lsu_addr[2:0];
            we_q     <= i_riscv_lsu_memwrite;
            memext_q <= i_riscv_lsu_memext;
            // Loads carry no byte enables; the whole word is returned and lane-selected later.
            strb_q   <= i_riscv_lsu_memwrite
                        ? (STRB_W'(strb_base(i_riscv_lsu_storesrc)) << i_riscv_lsu_addr[2:0])
                        : '0;
            wdata_q  <= i_riscv_lsu_memwrite
                        ? (i_riscv_lsu_storedata << {i_riscv_lsu_addr[2:0], 3'b000})
                        : '0;
         end
         if (capture_rdata) rdata_q <= i_riscv_lsu_dmem_rdata;
      end
   end

   riscv_lsu_extend #(
      .width (width)
   ) u_extend (
      .rdata    (rdata_q),
      .off      (off_q),
      .memext   (memext_q),
      .loaddata (ext_data)
   );

   always_comb begin
      o_riscv_lsu_dmem_req   = (state_q == ST_REQ);
      o_riscv_lsu_dmem_we    = o_riscv_lsu_dmem_req & we_q;
      o_riscv_lsu_dmem_addr  = o_riscv_lsu_dmem_req ? addr_q  : '0;
      o_riscv_lsu_dmem_wdata = o_riscv_lsu_dmem_req ? wdata_q : '0;
      o_riscv_lsu_dmem_strb  = o_riscv_lsu_dmem_req ? strb_q  : '0;
      o_riscv_lsu_done       = (state_q == ST_RESP);
      o_riscv_lsu_loaddata   = (o_riscv_lsu_done & ~we_q) ? ext_data : '0;
      o_riscv_lsu_stall      = accept | (state_q == ST_REQ) | (state_q == ST_WAIT)
                             | (state_q == ST_DRAIN);
      o_riscv_lsu_state      = state_q;
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: hand-computed load/store vectors, bus latency cases,
// misaligned/flush suppression and reset during an outstanding access.
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, memread, memwrite, misaligned, flush;
   logic [2:0]  memext;
   logic [1:0]  storesrc;
   logic [63:0] addr, storedata;
   logic        gnt, rvalid;
   logic [63:0] rdata;
   logic        req, we, done, stall;
   logic [63:0] dmem_addr, wdata, loaddata;
   logic [7:0]  strb;
   logic [2:0]  state;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];

   localparam logic [63:0] S_IDLE  = 64'd0;
   localparam logic [63:0] S_WAIT  = 64'd2;
   localparam logic [63:0] S_DRAIN = 64'd4;

   always #5 clk = ~clk;

   riscv_lsu dut (
      .i_riscv_lsu_clk        (clk),
      .i_riscv_lsu_rst        (rst_n),
      .i_riscv_lsu_valid      (valid),
      .i_riscv_lsu_memread    (memread),
      .i_riscv_lsu_memwrite   (memwrite),
      .i_riscv_lsu_memext     (memext),
      .i_riscv_lsu_storesrc   (storesrc),
      .i_riscv_lsu_addr       (addr),
      .i_riscv_lsu_storedata  (storedata),
      .i_riscv_lsu_misaligned (misaligned),
      .i_riscv_lsu_flush      (flush),
      .o_riscv_lsu_dmem_req   (req),
      .o_riscv_lsu_dmem_we    (we),
      .o_riscv_lsu_dmem_addr  (dmem_addr),
      .o_riscv_lsu_dmem_wdata (wdata),
      .o_riscv_lsu_dmem_strb  (strb),
      .i_riscv_lsu_dmem_gnt   (gnt),
      .i_riscv_lsu_dmem_rvalid(rvalid),
      .i_riscv_lsu_dmem_rdata (rdata),
      .o_riscv_lsu_loaddata   (loaddata),
      .o_riscv_lsu_done       (done),
      .o_riscv_lsu_stall      (stall),
      .o_riscv_lsu_state      (state)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      valid = 0; memread = 0; memwrite = 0; misaligned = 0; flush = 0;
      memext = 0; storesrc = 0; addr = 0; storedata = 0;
      gnt = 0; rvalid = 0; rdata = 0;
   endtask

   task automatic issue(input logic wr, input logic rd_too, input logic [2:0] mext,
                        input logic [1:0] ssrc, input logic [63:0] a, input logic [63:0] sd);
      step();
      valid = 1; memread = ~wr | rd_too; memwrite = wr;
      memext = mext; storesrc = ssrc; addr = a; storedata = sd;
   endtask

   // One complete access: gnt_dly idle REQ cycles, then grant; rv_dly WAIT cycles
   // with rvalid on the last (0 = rvalid together with gnt).
   task automatic access(input string tag, input logic wr, input logic rd_too,
                         input logic [2:0] mext, input logic [1:0] ssrc,
                         input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rd,
                         input int gnt_dly, input int rv_dly, input logic [63:0] exp_ld,
                         input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
      exp_q.push_back(exp_ld);
      issue(wr, rd_too, mext, ssrc, a, sd);
      #4;
      check({tag, "_accept_stall"}, stall, 1);
      check({tag, "_accept_req"}, req, 0);
      step();
      clear_inputs();
      for (int i = 0; i <= gnt_dly; i++) begin
         if (i == gnt_dly) begin
            gnt = 1;
            if (rv_dly == 0) begin rvalid = 1; rdata = rd; end
         end
         #4;
         check({tag, "_req"}, req, 1);
         check({tag, "_addr"}, dmem_addr, {a[63:3], 3'b000});
         check({tag, "_we"}, we, wr);
         check({tag, "_strb"}, strb, exp_strb);
         check({tag, "_wdata"}, wdata, exp_wdata);
         check({tag, "_req_stall"}, stall, 1);
         step();
         gnt = 0; rvalid = 0;
      end
      for (int i = 1; i <= rv_dly; i++) begin
         if (i == rv_dly) begin rvalid = 1; rdata = rd; end
         #4;
         check({tag, "_wait_state"}, state, S_WAIT);
         check({tag, "_wait_stall"}, stall, 1);
         check({tag, "_wait_req"}, req, 0);
         step();
         rvalid = 0;
      end
      #4;
      check({tag, "_done"}, done, 1);
      check({tag, "_resp_stall"}, stall, 0);
      check({tag, "_loaddata"}, loaddata, exp_q.pop_front());
      step();
      #4;
      check({tag, "_done_clr"}, done, 0);
      check({tag, "_idle"}, state, S_IDLE);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      rst_n = 0;
      clear_inputs();
      #3;
      check("rst_req", req, 0);
      check("rst_stall", stall, 0);
      check("rst_done", done, 0);
      check("rst_loaddata", loaddata, 0);
      check("rst_state", state, S_IDLE);
      step();
      rst_n = 1;

      // 1: LB, grant and response in the first REQ cycle
      access("t1_lb", 0, 0, 3'b000, 2'b00, 64'h1003, 0, 64'h0000_0000_8000_0000, 0, 0,
             64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0);
      // 2: SH into the top halfword, granted after one wait, ack one cycle later
      access("t2_sh", 1, 0, 3'b000, 2'b01, 64'h1006, 64'hBEEF, 0, 1, 1,
             64'h0, 8'hC0, 64'hBEEF_0000_0000_0000);
      // 3: LWU, grant delayed 3 cycles, rvalid 2 cycles after grant
      access("t3_lwu", 0, 0, 3'b110, 2'b00, 64'h2004, 0, 64'h8765_4321_0000_0000, 3, 2,
             64'h0000_0000_8765_4321, 8'h00, 64'h0);

      access("lh",    0, 0, 3'b001, 2'b00, 64'h3002, 0, 64'h0000_0000_F123_0000, 0, 0,
             64'hFFFF_FFFF_FFFF_F123, 8'h00, 64'h0);
      access("lhu",   0, 0, 3'b101, 2'b00, 64'h3002, 0, 64'h0000_0000_F123_0000, 0, 1,
             64'h0000_0000_0000_F123, 8'h00, 64'h0);
      access("ld",    0, 0, 3'b011, 2'b00, 64'h4000, 0, 64'h0123_4567_89AB_CDEF, 1, 0,
             64'h0123_4567_89AB_CDEF, 8'h00, 64'h0);
      access("lbu",   0, 0, 3'b100, 2'b00, 64'h5007, 0, 64'hA500_0000_0000_0000, 0, 0,
             64'h0000_0000_0000_00A5, 8'h00, 64'h0);
      access("lw",    0, 0, 3'b010, 2'b00, 64'h7000, 0, 64'hFFFF_FFFF_7FFF_FFFF, 0, 0,
             64'h0000_0000_7FFF_FFFF, 8'h00, 64'h0);
      access("ext111",0, 0, 3'b111, 2'b00, 64'h6000, 0, 64'hDEAD_BEEF_CAFE_F00D, 0, 0,
             64'hDEAD_BEEF_CAFE_F00D, 8'h00, 64'h0);
      access("sb",    1, 0, 3'b000, 2'b00, 64'h8005, 64'h12, 0, 0, 0,
             64'h0, 8'h20, 64'h0000_1200_0000_0000);
      access("sw",    1, 0, 3'b000, 2'b10, 64'h9004, 64'h1122_3344, 0, 0, 0,
             64'h0, 8'hF0, 64'h1122_3344_0000_0000);
      access("sd_rw", 1, 1, 3'b011, 2'b11, 64'hA000, 64'h0102_0304_0506_0708, 0, 0, 0,
             64'h0, 8'hFF, 64'h0102_0304_0506_0708);

      // 4: misaligned access is suppressed entirely
      step();
      valid = 1; memread = 1; memext = 3'b010; addr = 64'h1002; misaligned = 1;
      #4;
      check("t4_stall", stall, 0);
      check("t4_req", req, 0);
      step();
      clear_inputs();
      #4;
      check("t4_state", state, S_IDLE);
      check("t4_req_next", req, 0);
      check("t4_done", done, 0);

      // flush in IDLE blocks acceptance
      step();
      valid = 1; memread = 1; addr = 64'h1000; flush = 1;
      #4;
      check("flush_idle_stall", stall, 0);
      step();
      clear_inputs();
      #4;
      check("flush_idle_state", state, S_IDLE);

      // 5a: flush in REQ without grant
      issue(0, 0, 3'b011, 2'b00, 64'h1100, 0);
      step();
      clear_inputs();
      flush = 1;
      step();
      flush = 0;
      #4;
      check("t5a_req", req, 0);
      check("t5a_state", state, S_IDLE);
      check("t5a_stall", stall, 0);
      check("t5a_done", done, 0);

      // 5b: flush in WAIT -> DRAIN, response discarded
      issue(0, 0, 3'b011, 2'b00, 64'h1200, 0);
      step();
      clear_inputs();
      gnt = 1;
      step();
      gnt = 0; flush = 1;
      #4;
      check("t5b_wait_stall", stall, 1);
      step();
      flush = 0;
      #4;
      check("t5b_drain_state", state, S_DRAIN);
      check("t5b_drain_stall", stall, 1);
      check("t5b_drain_done", done, 0);
      step();
      rvalid = 1; rdata = 64'h5555_5555_5555_5555;
      #4;
      check("t5b_rv_done", done, 0);
      check("t5b_rv_stall", stall, 1);
      step();
      rvalid = 0;
      #4;
      check("t5b_idle", state, S_IDLE);
      check("t5b_done_after", done, 0);
      check("t5b_stall_after", stall, 0);

      // valid held high through RESP must not start a new access that cycle
      issue(0, 0, 3'b011, 2'b00, 64'h1300, 0);
      step();
      clear_inputs();
      gnt = 1; rvalid = 1; rdata = 64'h0000_0000_0000_0042;
      step();
      gnt = 0; rvalid = 0;
      valid = 1; memread = 1; memext = 3'b011; addr = 64'h1400;
      #4;
      check("reaccept_done", done, 1);
      check("reaccept_ld", loaddata, 64'h42);
      check("reaccept_stall", stall, 0);
      step();
      clear_inputs();
      #4;
      check("reaccept_state", state, S_IDLE);

      // 6: reset during WAIT, then a stale rvalid
      issue(0, 0, 3'b011, 2'b00, 64'h1500, 0);
      step();
      clear_inputs();
      gnt = 1;
      step();
      gnt = 0;
      #2;
      rst_n = 0;
      #1;
      check("t6_state", state, S_IDLE);
      check("t6_req", req, 0);
      check("t6_stall", stall, 0);
      check("t6_done", done, 0);
      check("t6_loaddata", loaddata, 0);
      step();
      rst_n = 1;
      rvalid = 1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      #4;
      check("t6_stale_done", done, 0);
      check("t6_stale_req", req, 0);
      step();
      rvalid = 0;
      #4;
      check("t6_stale_state", state, S_IDLE);
      check("t6_stale_done2", done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
